// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, FSM state
// encoding and the select codes that the datapath and ALUControl decode.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // The debug port exposes these values, so the encoding is frozen.
  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    JUMP   = 4'd10,
    ADDIEX = 4'd11,
    ADDIWB = 4'd12
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the main control FSM (master) and the datapath (slave).
interface mips_multicycle_control_if;
  import mips_pkg::*;

  logic [5:0] opcode;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal, state
  );

  modport slave (
    output opcode,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal, state
  );
endinterface

// File: rtl/mips_control_decode.sv
// Moore output decoder: maps the current FSM state to every datapath control.
module mips_control_decode
  import mips_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    // NOTE: the all-zero default ahead of the case keeps every field assigned on
    // every path, so no latch is inferred and unlisted controls stay inactive.
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
      end
      DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMADR, ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      ADDIWB: ctrl.reg_write = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS: state register, opcode latch,
// next-state logic and sticky illegal-opcode flag; outputs come from the decoder.
module mips_multicycle_control
  import mips_pkg::*;
(
  input logic                        clk,
  input logic                        rst_n,
  mips_multicycle_control_if.master  bus
);

  state_t     state_q;
  logic [5:0] op_q;
  logic       illegal_q;
  ctrl_t      ctrl;

  // NOTE: state, latch and flag are all updated with non-blocking assignments so
  // every branch sees the pre-edge values, matching the registered hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE:   state_q <= FETCH;
        FETCH:  state_q <= DECODE;
        DECODE: begin
          op_q <= bus.opcode;
          case (bus.opcode)
            OP_LW, OP_SW: state_q <= MEMADR;
            OP_RTYPE:     state_q <= EXEC;
            OP_BEQ:       state_q <= BRANCH;
            OP_J:         state_q <= JUMP;
            OP_ADDI:      state_q <= ADDIEX;
            default: begin
              state_q   <= FETCH;
              illegal_q <= 1'b1;
            end
          endcase
        end
        // Later states look only at the copy taken in DECODE, not the live IR.
        MEMADR: state_q <= (op_q == OP_SW) ? MEMWR : MEMRD;
        MEMRD:  state_q <= MEMWB;
        EXEC:   state_q <= ALUWB;
        ADDIEX: state_q <= ADDIWB;
        default: state_q <= FETCH;
      endcase
    end
  end

  // Outputs decode the reset-cleared state directly, so asserting rst_n low
  // silences every strobe at once without waiting for a clock edge.
  mips_control_decode u_decode (
    .state (state_q),
    .ctrl  (ctrl)
  );

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.IorD        = ctrl.i_or_d;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.illegal     = illegal_q;
  assign bus.state       = state_q;

endmodule
